buck_pwm_generator: RTL and testbench

//  Gate-drive generator for the 2-phase interleaved discharge buck; consumer end of the one-cycle controller.

---
 rtl/buck_pwm_pkg.sv | 34 +++
 rtl/buck_pwm_channel.sv | 75 +++++++
 rtl/buck_pwm_generator.sv | 147 ++++++++++++++
 tb/tb_buck_pwm_generator.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/buck_pwm_pkg.sv
// Shared definitions for the 2-phase interleaved buck gate-drive generator.
// Contents:
//   pwm_state_e  - controller state (IDLE / RUN / FAULT)
//   *_DEF        - default timing constants in clk cycles
//   clamp_ton    - limits a requested on-time to [MIN_ON, MAX_ON], dropping runts to 0
package buck_pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } pwm_state_e;

  localparam logic [15:0] PERIOD_DEF = 16'd400;
  localparam logic [15:0] MAX_ON_DEF = 16'd200;
  localparam logic [15:0] MIN_ON_DEF = 16'd4;
  localparam logic [15:0] DEAD_DEF   = 16'd10;

  // Requests at or above max_on saturate; requests too short to be useful produce no pulse.
  function automatic logic [15:0] clamp_ton(input logic [15:0] req,
                                            input logic [15:0] max_on,
                                            input logic [15:0] min_on);
    logic [15:0] res;
    if (req >= max_on) begin
      res = max_on;
    end else if (req < min_on) begin
      res = 16'd0;
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/buck_pwm_channel.sv
// One phase of the buck gate drive: on-time latch plus high-side / low-side compare.
// Everything is computed from the values the timer and state will take after the
// coming edge, so the registered gates line up with the registered timer output.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   run_nxt    - controller will be in RUN after this edge
//   wrap_nxt   - this phase's timer becomes 0 on this edge
//   t_nxt      - this phase's timer value after this edge
//   ton_req    - requested high-side on-time (clk cycles)
//   gate_hs    - registered high-side gate
//   gate_ls    - registered low-side gate
module buck_pwm_channel
  import buck_pwm_pkg::*;
#(
  parameter logic [15:0] PERIOD = PERIOD_DEF,
  parameter logic [15:0] MAX_ON = MAX_ON_DEF,
  parameter logic [15:0] MIN_ON = MIN_ON_DEF,
  parameter logic [15:0] DEAD   = DEAD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_nxt,
  input  logic        wrap_nxt,
  input  logic [15:0] t_nxt,
  input  logic [15:0] ton_req,
  output logic        gate_hs,
  output logic        gate_ls
);

  logic [15:0] ton_r;
  logic [15:0] ton_nxt_s;
  logic [16:0] ls_start_s;
  logic        hs_nxt_s;
  logic        ls_nxt_s;
  logic        gate_hs_r;
  logic        gate_ls_r;

  // Next on-time and next gate levels; the on-time only moves at this phase's wrap.
  always_comb begin
    ton_nxt_s  = 16'd0;
    ls_start_s = 17'd0;
    hs_nxt_s   = 1'b0;
    ls_nxt_s   = 1'b0;
    if (!run_nxt) begin
      ton_nxt_s = 16'd0;
    end else if (wrap_nxt) begin
      ton_nxt_s = clamp_ton(ton_req, MAX_ON, MIN_ON);
    end else begin
      ton_nxt_s = ton_r;
    end
    // 17-bit sum so a large on-time cannot wrap into the LS window.
    ls_start_s = {1'b0, ton_nxt_s} + {1'b0, DEAD};
    hs_nxt_s   = run_nxt && (t_nxt < ton_nxt_s);
    // When ls_start reaches PERIOD-DEAD the window is empty and LS stays low.
    ls_nxt_s   = run_nxt && (ton_nxt_s != 16'd0) &&
                 ({1'b0, t_nxt} >= ls_start_s) && (t_nxt < (PERIOD - DEAD));
  end

  // On-time latch and gate registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ton_r     <= 16'd0;
      gate_hs_r <= 1'b0;
      gate_ls_r <= 1'b0;
    end else begin
      ton_r     <= ton_nxt_s;
      gate_hs_r <= hs_nxt_s;
      gate_ls_r <= ls_nxt_s;
    end
  end

  assign gate_hs = gate_hs_r;
  assign gate_ls = gate_ls_r;

endmodule

// File: rtl/buck_pwm_generator.sv
// Gate-drive generator for the 2-phase interleaved discharge buck.
// Owns the switching timebase (phase-0 counter and its 180-degree copy), the
// IDLE/RUN/FAULT controller and period_start; each phase's gates come from a
// buck_pwm_channel instance.
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   enable                  - request to run switching
//   fault_in                - level trip, forces FAULT
//   inductor_charging_time  - requested HS on-time, clk cycles
//   timer_buck_4us_0        - phase-0 counter 0..PERIOD-1
//   timer_buck_interleave   - phase-1 counter, half a period ahead
//   gate_hs, gate_ls        - per-phase gates
//   period_start            - pulse while timer_buck_4us_0 == 0
//   running, fault_latched  - state == RUN / state == FAULT
module buck_pwm_generator
  import buck_pwm_pkg::*;
#(
  parameter logic [15:0] PERIOD = PERIOD_DEF,
  parameter logic [15:0] MAX_ON = MAX_ON_DEF,
  parameter logic [15:0] MIN_ON = MIN_ON_DEF,
  parameter logic [15:0] DEAD   = DEAD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fault_in,
  input  logic [15:0] inductor_charging_time,
  output logic [15:0] timer_buck_4us_0,
  output logic [15:0] timer_buck_interleave,
  output logic [1:0]  gate_hs,
  output logic [1:0]  gate_ls,
  output logic        period_start,
  output logic        running,
  output logic        fault_latched
);

  localparam logic [15:0] HALF = PERIOD >> 1;

  pwm_state_e  state_r;
  pwm_state_e  state_nxt_s;
  logic [15:0] t0_r;
  logic [15:0] t1_r;
  logic [15:0] t0_nxt_s;
  logic [15:0] t1_nxt_s;
  logic        wrap0_s;
  logic        wrap1_s;
  logic        run_nxt_s;
  logic        period_start_r;
  logic        running_r;
  logic        fault_latched_r;

  // Free-running timer increments and wrap strobes.
  always_comb begin
    wrap0_s  = (t0_r == (PERIOD - 16'd1));
    wrap1_s  = (t1_r == (PERIOD - 16'd1));
    t0_nxt_s = wrap0_s ? 16'd0 : (t0_r + 16'd1);
    t1_nxt_s = wrap1_s ? 16'd0 : (t1_r + 16'd1);
  end

  // Controller next state; fault has priority, RUN only starts on a phase-0 wrap.
  always_comb begin
    state_nxt_s = state_r;
    if (fault_in) begin
      state_nxt_s = ST_FAULT;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable && wrap0_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_FAULT: begin
          if (!enable) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_FAULT;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
    run_nxt_s = (state_nxt_s == ST_RUN);
  end

  // Timers, state register and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      t0_r            <= 16'd0;
      t1_r            <= HALF;
      state_r         <= ST_IDLE;
      period_start_r  <= 1'b0;
      running_r       <= 1'b0;
      fault_latched_r <= 1'b0;
    end else begin
      t0_r            <= t0_nxt_s;
      t1_r            <= t1_nxt_s;
      state_r         <= state_nxt_s;
      period_start_r  <= wrap0_s;
      running_r       <= run_nxt_s;
      fault_latched_r <= (state_nxt_s == ST_FAULT);
    end
  end

  buck_pwm_channel #(
    .PERIOD(PERIOD), .MAX_ON(MAX_ON), .MIN_ON(MIN_ON), .DEAD(DEAD)
  ) u_ch0 (
    .clk     (clk),
    .rst     (rst),
    .run_nxt (run_nxt_s),
    .wrap_nxt(wrap0_s),
    .t_nxt   (t0_nxt_s),
    .ton_req (inductor_charging_time),
    .gate_hs (gate_hs[0]),
    .gate_ls (gate_ls[0])
  );

  buck_pwm_channel #(
    .PERIOD(PERIOD), .MAX_ON(MAX_ON), .MIN_ON(MIN_ON), .DEAD(DEAD)
  ) u_ch1 (
    .clk     (clk),
    .rst     (rst),
    .run_nxt (run_nxt_s),
    .wrap_nxt(wrap1_s),
    .t_nxt   (t1_nxt_s),
    .ton_req (inductor_charging_time),
    .gate_hs (gate_hs[1]),
    .gate_ls (gate_ls[1])
  );

  assign timer_buck_4us_0      = t0_r;
  assign timer_buck_interleave = t1_r;
  assign period_start          = period_start_r;
  assign running               = running_r;
  assign fault_latched         = fault_latched_r;

endmodule

// File: tb/tb_buck_pwm_generator.sv
// Self-checking bench for buck_pwm_generator: a cycle-level behavioural model
// (timer as cycle count mod PERIOD, on-times, gate windows) checked every cycle,
// plus directed period measurements pinned to hand-computed values.
module tb_buck_pwm_generator;

  localparam int PER  = 400;
  localparam int HALF = 200;
  localparam int MAXO = 200;
  localparam int MINO = 4;
  localparam int DT   = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        fault_in = 1'b0;
  logic [15:0] ton_req = 16'd100;
  logic [15:0] timer_buck_4us_0;
  logic [15:0] timer_buck_interleave;
  logic [1:0]  gate_hs;
  logic [1:0]  gate_ls;
  logic        period_start;
  logic        running;
  logic        fault_latched;

  int n_vec = 0;
  int n_err = 0;

  buck_pwm_generator dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable                (enable),
    .fault_in              (fault_in),
    .inductor_charging_time(ton_req),
    .timer_buck_4us_0      (timer_buck_4us_0),
    .timer_buck_interleave (timer_buck_interleave),
    .gate_hs               (gate_hs),
    .gate_ls               (gate_ls),
    .period_start          (period_start),
    .running               (running),
    .fault_latched         (fault_latched)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampf(input int r);
    if (r >= MAXO) return MAXO;
    if (r < MINO) return 0;
    return r;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  int m_valid = 0;
  int m_cyc = 0;        // cycles since last reset; timer = m_cyc mod PER
  int m_state = 0;      // 0 idle, 1 run, 2 fault
  int m_ton[2] = '{0, 0};
  int m_ps = 0;

  always @(posedge clk) begin
    int t[2];
    int e_hs, e_ls;
    if (rst) begin
      m_valid = 1; m_cyc = 0; m_state = 0; m_ton[0] = 0; m_ton[1] = 0; m_ps = 0;
    end else if (m_valid != 0) begin
      m_cyc = m_cyc + 1;
      if (fault_in) m_state = 2;
      else if (m_state == 0 && enable && (m_cyc % PER) == 0) m_state = 1;
      else if (m_state != 0 && !enable) m_state = 0;
      t[0] = m_cyc % PER;
      t[1] = (m_cyc + HALF) % PER;
      for (int k = 0; k < 2; k++) begin
        if (m_state != 1) m_ton[k] = 0;
        else if (t[k] == 0) m_ton[k] = clampf(int'(ton_req));
      end
      m_ps = (t[0] == 0) ? 1 : 0;
    end
    t[0] = m_cyc % PER;
    t[1] = (m_cyc + HALF) % PER;
    #2;
    if (m_valid != 0) begin
      check("timer0", int'(timer_buck_4us_0), t[0]);
      check("timer1", int'(timer_buck_interleave), t[1]);
      check("period_start", int'(period_start), m_ps);
      check("running", int'(running), (m_state == 1) ? 1 : 0);
      check("fault_latched", int'(fault_latched), (m_state == 2) ? 1 : 0);
      for (int k = 0; k < 2; k++) begin
        e_hs = (m_state == 1 && t[k] < m_ton[k]) ? 1 : 0;
        e_ls = (m_state == 1 && m_ton[k] != 0 && t[k] >= m_ton[k] + DT && t[k] < PER - DT) ? 1 : 0;
        check($sformatf("gate_hs%0d", k), int'(gate_hs[k]), e_hs);
        check($sformatf("gate_ls%0d", k), int'(gate_ls[k]), e_ls);
        check($sformatf("overlap%0d", k), int'(gate_hs[k] & gate_ls[k]), 0);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_t0(input int v);
    int i;
    i = 0;
    while (int'(timer_buck_4us_0) != v && i < 1000) begin
      @(negedge clk);
      i++;
    end
    if (i >= 1000) check("wait_t0_timeout", int'(timer_buck_4us_0), v);
  endtask

  // Counts over one full period starting at a negedge where t0 == 0.
  task automatic measure(output int hs, output int ls, output int first_ls, output int first_hs1);
    hs = 0; ls = 0; first_ls = -1; first_hs1 = -1;
    for (int i = 0; i < PER; i++) begin
      if (gate_hs[0]) hs++;
      if (gate_ls[0]) begin
        ls++;
        if (first_ls < 0) first_ls = int'(timer_buck_4us_0);
      end
      if (gate_hs[1] && first_hs1 < 0) first_hs1 = int'(timer_buck_4us_0);
      @(negedge clk);
    end
  endtask

  initial begin
    int hs, ls, fls, fh1;
    // reset values
    cyc(3);
    check("rst_t0", int'(timer_buck_4us_0), 0);
    check("rst_t1", int'(timer_buck_interleave), 200);
    check("rst_gates", int'({gate_hs, gate_ls}), 0);
    check("rst_ps", int'(period_start), 0);
    rst = 1'b0;

    // 1: ton=100 steady
    enable = 1'b1;
    cyc(1);
    wait_t0(0);
    check("run_at_wrap", int'(running), 1);
    measure(hs, ls, fls, fh1);
    check("t1_hs_count", hs, 100);
    check("t1_ls_count", ls, 280);
    check("t1_ls_first", fls, 110);
    check("t1_hs1_first", fh1, 200);

    // 2: clamp to MAX_ON, then runt
    ton_req = 16'd350;
    cyc(1); wait_t0(0);
    measure(hs, ls, fls, fh1);
    check("max_hs_count", hs, 200);
    check("max_ls_count", ls, 180);
    check("max_ls_first", fls, 210);
    ton_req = 16'd3;
    cyc(1); wait_t0(0);
    measure(hs, ls, fls, fh1);
    check("runt_hs_count", hs, 0);
    check("runt_ls_count", ls, 0);
    ton_req = 16'd0;
    cyc(1); wait_t0(0);
    measure(hs, ls, fls, fh1);
    check("zero_hs_count", hs, 0);

    // 3: mid-period change
    ton_req = 16'd100;
    cyc(1); wait_t0(0);
    wait_t0(50);
    ton_req = 16'd150;
    cyc(1); wait_t0(0);
    measure(hs, ls, fls, fh1);
    check("chg_hs_count", hs, 150);

    // 4: one-cycle fault while HS0 high
    wait_t0(30);
    fault_in = 1'b1;
    cyc(1);
    fault_in = 1'b0;
    check("fault_gates", int'({gate_hs, gate_ls}), 0);
    check("fault_latched", int'(fault_latched), 1);
    cyc(50);
    check("fault_hold", int'(fault_latched), 1);
    enable = 1'b0;
    cyc(2);
    check("fault_clear", int'(fault_latched), 0);
    enable = 1'b1;
    cyc(1); wait_t0(0);
    check("rerun", int'(running), 1);

    // 5: enable drop mid-period, then reset mid-RUN
    wait_t0(120);
    enable = 1'b0;
    cyc(1);
    check("drop_running", int'(running), 0);
    check("drop_gates", int'({gate_hs, gate_ls}), 0);
    check("drop_timer", int'(timer_buck_4us_0), 121);
    enable = 1'b1;
    cyc(1); wait_t0(20);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_mid_t1", int'(timer_buck_interleave), 200);
    check("rst_mid_run", int'(running), 0);

    // 6: randomized ton/enable/fault/reset
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) < 4) ton_req = 16'($urandom_range(0, 420));
      if ($urandom_range(0, 999) < 3) enable = ~enable;
      fault_in = ($urandom_range(0, 999) < 5) ? 1'b1 : 1'b0;
      rst = ($urandom_range(0, 1999) < 2) ? 1'b1 : 1'b0;
      if (!enable && $urandom_range(0, 99) < 5) enable = 1'b1;
      cyc(1);
    end
    rst = 1'b0; fault_in = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
